// File: rtl/sync_updown_counter.sv
// Synchronous up/down modulo counter with count-enable prescaler, parallel load,
// terminal-count and wrap outputs for ripple-free cascading.
module sync_updown_counter #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             Wrap
);

    localparam int unsigned      PSW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] Q_MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W  = (WIDTH + 1)'(MODULUS);
    localparam logic [PSW-1:0]   PS_MAX = PSW'(PRESCALE - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [PSW-1:0]   ps_q, ps_d;
    logic             wrap_q, wrap_d;
    logic             tick;

    assign tick = En & (ps_q == PS_MAX);

    // Next-state: load beats counting; out-of-range load values clamp to the top count
    always_comb begin
        q_d    = q_q;
        ps_d   = ps_q;
        wrap_d = 1'b0;
        if (Load) begin
            q_d  = ({1'b0, D} < MOD_W) ? D : Q_MAX;
            ps_d = '0;
        end else begin
            if (En) begin
                ps_d = (ps_q == PS_MAX) ? '0 : ps_q + PSW'(1);
            end
            if (tick) begin
                if (Up) begin
                    if (q_q < Q_MAX) begin
                        q_d = q_q + WIDTH'(1);
                    end else begin
                        q_d    = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    if (q_q > '0) begin
                        q_d = q_q - WIDTH'(1);
                    end else begin
                        q_d    = Q_MAX;
                        wrap_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            q_q    <= '0;
            ps_q   <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            ps_q   <= ps_d;
            wrap_q <= wrap_d;
        end
    end

    // Terminal count is combinational so the next stage sees it on the same edge
    assign TC   = tick & ~Load & (Up ? (q_q == Q_MAX) : (q_q == '0));
    assign Q    = q_q;
    assign Wrap = wrap_q;

endmodule
